// File: rtl/sr_ff_lockstep_checker_if.sv
// Handshake bundle between the triple SR flip-flop stage and its lockstep checker.
// The master drives the S/R drive, the three Q copies and clr_fault. The slave returns the verdict.
interface sr_ff_lockstep_checker_if #(
  parameter int CNT_W = 8
);
  logic             s;
  logic             r;
  logic             q_jk;
  logic             q_d;
  logic             q_t;
  logic             clr_fault;
  logic             q_vote;
  logic             mismatch;
  logic             illegal_sr;
  logic             fault;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state;

  modport master (
    output s, r, q_jk, q_d, q_t, clr_fault,
    input  q_vote, mismatch, illegal_sr,
    input  fault, err_cnt, state
  );

  modport slave (
    input  s, r, q_jk, q_d, q_t, clr_fault,
    output q_vote, mismatch, illegal_sr,
    output fault, err_cnt, state
  );
endinterface

// File: rtl/sr_ff_lockstep_checker.sv
// Lockstep checker for the triple SR flip-flop stage.
// Provides a majority vote, a golden SR model, and escalation to a sticky fault.
module sr_ff_lockstep_checker #(
  parameter int PERSIST = 2,
  parameter int CNT_W   = 8
) (
  input logic                   clk,
  input logic                   rst,
  sr_ff_lockstep_checker_if.slave bus
);
  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [3:0] PERSIST_L = 4'(PERSIST);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [CNT_W-1:0] err_q;
  logic             q_exp_q, valid_q;
  logic             vote_q, mis_q, ill_q;
  logic             maj, split, m;

  assign maj = (bus.q_jk & bus.q_d)
             | (bus.q_jk & bus.q_t)
             | (bus.q_d & bus.q_t);
  assign split = (bus.q_jk != bus.q_d)
               | (bus.q_jk != bus.q_t);
  assign m = split | (valid_q & (maj ^ q_exp_q));

  // Golden model: S=R=1 leaves the copies legitimately undefined
  always_ff @(posedge clk) begin
    if (rst) begin
      q_exp_q <= 1'b0;
      valid_q <= 1'b1;
    end else begin
      unique case (1'b1)
        bus.s && !bus.r: begin
          q_exp_q <= 1'b1;
          valid_q <= 1'b1;
        end
        !bus.s && bus.r: begin
          q_exp_q <= 1'b0;
          valid_q <= 1'b1;
        end
        bus.s && bus.r: valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q <= 1'b0;
      mis_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      vote_q <= maj;
      mis_q  <= m;
      ill_q  <= bus.s & bus.r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_fault) begin
      err_q <= '0;
    end else if (m && (err_q != '1)) begin
      err_q <= err_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OK;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (bus.clr_fault) begin
      state_d = OK;
      run_d   = 4'd0;
    end else begin
      unique case (state_q)
        OK: begin
          if (m) begin
            run_d   = 4'd1;
            state_d = (PERSIST_L == 4'd1) ? FAULT : SUSPECT;
          end
        end
        SUSPECT: begin
          if (m) begin
            run_d = run_q + 4'd1;
            if (run_d == PERSIST_L) state_d = FAULT;
          end else begin
            state_d = OK;
            run_d   = 4'd0;
          end
        end
        FAULT: ;
        default: begin
          state_d = OK;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    bus.q_vote     = vote_q;
    bus.mismatch   = mis_q;
    bus.illegal_sr = ill_q;
    bus.err_cnt    = err_q;
    bus.state      = state_q;
    bus.fault      = (state_q == FAULT);
  end
endmodule

// File: tb/tb_sr_ff_lockstep_checker.sv
// Bench for sr_ff_lockstep_checker: a streak/sticky behavioural model checked every cycle.
// It also pins directed scenarios with literal expectations, using an 8-bit and a 2-bit error counter.
module tb_sr_ff_lockstep_checker;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_ff_lockstep_checker_if #(.CNT_W(8)) bus ();
  sr_ff_lockstep_checker_if #(.CNT_W(2)) bus2 ();

  assign bus2.s         = bus.s;
  assign bus2.r         = bus.r;
  assign bus2.q_jk      = bus.q_jk;
  assign bus2.q_d       = bus.q_d;
  assign bus2.q_t       = bus.q_t;
  assign bus2.clr_fault = bus.clr_fault;

  sr_ff_lockstep_checker #(.PERSIST(P), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sr_ff_lockstep_checker #(.PERSIST(P), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Model state
  bit e_q, e_valid, sticky;
  int streak, errs;
  bit e_vote, e_mis, e_ill;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int ones;
    bit m, mj;
    if (rst) begin
      e_q = 0; e_valid = 1; sticky = 0;
      streak = 0; errs = 0;
      e_vote = 0; e_mis = 0; e_ill = 0;
    end else begin
      ones = int'(bus.q_jk) + int'(bus.q_d) + int'(bus.q_t);
      mj = (ones >= 2);
      m = (ones != 0 && ones != 3) || (e_valid && mj != e_q);
      e_vote = mj;
      e_mis = m;
      e_ill = bus.s && bus.r;
      if (bus.clr_fault) begin
        streak = 0; sticky = 0; errs = 0;
      end else if (m) begin
        errs++;
        streak++;
        if (streak >= P) sticky = 1;
      end else if (!sticky) begin
        streak = 0;
      end
      if (bus.s && !bus.r) begin e_q = 1; e_valid = 1; end
      else if (!bus.s && bus.r) begin e_q = 0; e_valid = 1; end
      else if (bus.s && bus.r) e_valid = 0;
    end
  end

  always @(negedge clk) begin
    int es;
    if (started) begin
      es = sticky ? 2 : (streak > 0 ? 1 : 0);
      chk("m_vote", int'(bus.q_vote), int'(e_vote));
      chk("m_mis", int'(bus.mismatch), int'(e_mis));
      chk("m_ill", int'(bus.illegal_sr), int'(e_ill));
      chk("m_state", int'(bus.state), es);
      chk("m_fault", int'(bus.fault), int'(sticky));
      chk("m_err8", int'(bus.err_cnt), errs > 255 ? 255 : errs);
      chk("m_err2", int'(bus2.err_cnt), errs > 3 ? 3 : errs);
      chk("m_state2", int'(bus2.state), es);
    end
  end

  task automatic cyc(bit s, bit r, bit jk, bit d, bit t, bit clr);
    bus.s = s; bus.r = r;
    bus.q_jk = jk; bus.q_d = d; bus.q_t = t;
    bus.clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0);
    started = 1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_err", int'(bus.err_cnt), 0);
    chk("rst_vote", int'(bus.q_vote), 0);
    chk("rst_fault", int'(bus.fault), 0);
    rst = 0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    chk("set_vote", int'(bus.q_vote), 1);
    chk("set_mis", int'(bus.mismatch), 0);
    chk("set_state", int'(bus.state), 0);

    cyc(1, 1, 1, 1, 1, 0);
    chk("ill_pulse", int'(bus.illegal_sr), 1);
    chk("ill_nomis", int'(bus.mismatch), 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("ill_mis", int'(bus.mismatch), 1);
    chk("ill_vote", int'(bus.q_vote), 0);
    chk("ill_state", int'(bus.state), 1);
    chk("ill_drop", int'(bus.illegal_sr), 0);

    cyc(0, 1, 0, 0, 0, 0);
    chk("recov_state", int'(bus.state), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_err", int'(bus.err_cnt), 0);

    cyc(0, 0, 0, 0, 1, 0);
    chk("stk1_state", int'(bus.state), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("stk2_state", int'(bus.state), 2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("stk3_state", int'(bus.state), 2);
    chk("stk_fault", int'(bus.fault), 1);
    chk("stk_err", int'(bus.err_cnt), 3);

    cyc(0, 0, 0, 0, 1, 1);
    chk("clrm_state", int'(bus.state), 0);
    chk("clrm_err", int'(bus.err_cnt), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("post_state", int'(bus.state), 1);
    chk("post_err", int'(bus.err_cnt), 1);

    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("sat_err2", int'(bus2.err_cnt), 3);
    chk("sat_err8", int'(bus.err_cnt), 5);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("gl_state", int'(bus.state), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("gl_ok", int'(bus.state), 0);
    chk("gl_fault", int'(bus.fault), 0);

    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    chk("exp_state", int'(bus.state), 2);
    chk("exp_vote", int'(bus.q_vote), 1);
    rst = 1;
    cyc(0, 0, 1, 1, 1, 0);
    chk("rf_state", int'(bus.state), 0);
    chk("rf_fault", int'(bus.fault), 0);
    chk("rf_err", int'(bus.err_cnt), 0);
    chk("rf_vote", int'(bus.q_vote), 0);
    chk("rf_mis", int'(bus.mismatch), 0);
    rst = 0;

    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
